lfo_wavegen_hd: RTL

- Parametrised low-frequency oscillator (LFO) for the audio effects modulation path, e.g. tremolo and vibrato depth control.
- Uses a phase accumulator with a runtime-programmable increment.
- Sine output comes from a quarter-wave table with mirroring; triangle, saw and square are also selectable.
- Emits one unsigned, mid-offset sample per internal sample tick, qualified by a VALID strobe.

---
 rtl/lfo_wavegen_hd.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lfo_wavegen_hd.sv
// Low-frequency oscillator: phase accumulator feeding a sine/triangle/saw/square
// sample pipeline. Define LFO_DEPTH_EN to add a DEPTH input and a scaling stage.
module lfo_wavegen_hd #(
    parameter int OUT_W      = 10,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 6,
    parameter int TICK_DIV   = 223
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               freq_we,
    input  logic [PHASE_W-1:0] freq,
    input  logic               phase_rst,
    input  logic [1:0]         mode,
`ifdef LFO_DEPTH_EN
    input  logic [7:0]         depth,
`endif
    output logic [OUT_W-1:0]   sample,
    output logic               valid
);
    localparam int MID   = 2 ** (OUT_W - 1);
    localparam int AMP   = MID - 1;
    localparam int Q     = 2 ** LUT_ADDR_W;
    localparam int SW    = OUT_W + 1;
    localparam int PW    = LUT_ADDR_W + 2;
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic signed [SW-1:0]  MID_S    = SW'(MID);
    localparam logic signed [SW-1:0]  AMP_S    = SW'(AMP);
    localparam logic [LUT_ADDR_W:0]   Q_LUT    = (LUT_ADDR_W + 1)'(Q);
    localparam logic [OUT_W-1:0]      TRI_Q    = OUT_W'(MID);

    // Quarter-wave table round(511*sin(pi*k/128)); its size ties it to OUT_W=10, LUT_ADDR_W=6.
    localparam int SINE_TABLE [0:Q] = '{
          0,  13,  25,  38,  50,  63,  75,  87, 100, 112,
        124, 136, 148, 160, 172, 184, 196, 207, 218, 230,
        241, 252, 263, 273, 284, 294, 304, 314, 324, 334,
        343, 352, 361, 370, 379, 387, 395, 403, 410, 418,
        425, 432, 438, 445, 451, 456, 462, 467, 472, 477,
        481, 485, 489, 492, 496, 499, 501, 503, 505, 507,
        509, 510, 510, 511, 511
    };

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_TRI    = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_SQUARE = 2'd3
    } wave_t;

    logic [CNT_W-1:0]   count;
    logic               tick;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] phase;

    assign tick = en && (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

    // A load coinciding with a tick is seen only by the following tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc <= '0;
        end else if (freq_we) begin
            inc <= freq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (phase_rst) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase + inc;
        end
    end

    logic [PW-1:0]         sin_p;
    logic [1:0]            sin_quad;
    logic [LUT_ADDR_W-1:0] sin_off;
    logic [LUT_ADDR_W:0]   sin_addr;

    assign sin_p    = phase[PHASE_W-1 -: PW];
    assign sin_quad = sin_p[PW-1 -: 2];
    assign sin_off  = sin_p[LUT_ADDR_W-1:0];
    assign sin_addr = sin_quad[0] ? (Q_LUT - (LUT_ADDR_W + 1)'(sin_off))
                                  : (LUT_ADDR_W + 1)'(sin_off);

    logic [OUT_W:0]   tri_t;
    logic [1:0]       tri_quad;
    logic [OUT_W-2:0] tri_off;
    logic [OUT_W-1:0] tri_idx;
    logic [OUT_W-1:0] tri_mag;
    logic [OUT_W-1:0] tri_val;
    logic [OUT_W-1:0] saw_val;
    logic [OUT_W-1:0] sq_val;
    logic [OUT_W-1:0] raw_val;

    assign tri_t    = phase[PHASE_W-1 -: OUT_W + 1];
    assign tri_quad = tri_t[OUT_W -: 2];
    assign tri_off  = tri_t[OUT_W-2:0];
    assign tri_idx  = tri_quad[0] ? (TRI_Q - OUT_W'(tri_off)) : OUT_W'(tri_off);
    // Linear quarter table: round(AMP * idx / MID), so idx == MID lands exactly on AMP.
    assign tri_mag  = OUT_W'(((2 * OUT_W)'(tri_idx) * (2 * OUT_W)'(AMP)
                              + (2 * OUT_W)'(MID / 2)) >> (OUT_W - 1));
    assign tri_val  = OUT_W'(tri_quad[1] ? (MID_S - $signed({1'b0, tri_mag}))
                                         : (MID_S + $signed({1'b0, tri_mag})));
    assign saw_val  = phase[PHASE_W-1 -: OUT_W];
    assign sq_val   = OUT_W'(phase[PHASE_W-1] ? (MID_S - AMP_S) : (MID_S + AMP_S));

    always_comb begin
        raw_val = saw_val;
        case (wave_t'(mode))
            WAVE_TRI:    raw_val = tri_val;
            WAVE_SQUARE: raw_val = sq_val;
            default:     raw_val = saw_val;
        endcase
    end

    logic                s1_valid;
    wave_t               s1_mode;
    logic                s1_neg;
    logic [LUT_ADDR_W:0] s1_addr;
    logic [OUT_W-1:0]    s1_raw;
`ifdef LFO_DEPTH_EN
    logic [7:0]          s1_depth;
`endif

    // Stage 1 captures the pre-update phase view and mode at the tick; frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= WAVE_SINE;
            s1_neg   <= 1'b0;
            s1_addr  <= '0;
            s1_raw   <= '0;
`ifdef LFO_DEPTH_EN
            s1_depth <= '0;
`endif
        end else if (en) begin
            s1_valid <= tick;
            if (tick) begin
                s1_mode  <= wave_t'(mode);
                s1_neg   <= sin_quad[1];
                s1_addr  <= sin_addr;
                s1_raw   <= raw_val;
`ifdef LFO_DEPTH_EN
                s1_depth <= depth;
`endif
            end
        end
    end

    logic signed [SW-1:0] lut_mag;
    logic [OUT_W-1:0]     wave_val;

    assign lut_mag  = SW'(SINE_TABLE[s1_addr]);
    assign wave_val = (s1_mode == WAVE_SINE)
                    ? OUT_W'(s1_neg ? (MID_S - lut_mag) : (MID_S + lut_mag))
                    : s1_raw;

`ifdef LFO_DEPTH_EN
    logic                 s2_valid;
    logic [OUT_W-1:0]     s2_val;
    logic [7:0]           s2_depth;
    logic signed [SW-1:0] diff;
    logic signed [SW+8:0] prod;
    logic [OUT_W-1:0]     depth_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_val   <= OUT_W'(MID);
            s2_depth <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_val   <= wave_val;
                s2_depth <= s1_depth;
            end
        end
    end

    assign diff      = $signed({1'b0, s2_val}) - MID_S;
    assign prod      = diff * $signed({1'b0, s2_depth});
    assign depth_val = OUT_W'(MID_S + SW'(prod >>> 8));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= OUT_W'(MID);
            valid  <= 1'b0;
        end else begin
            valid <= en && s2_valid;
            if (en && s2_valid) begin
                sample <= depth_val;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= OUT_W'(MID);
            valid  <= 1'b0;
        end else begin
            valid <= en && s1_valid;
            if (en && s1_valid) begin
                sample <= wave_val;
            end
        end
    end
`endif

endmodule
